// File: rtl/fetch_issue_queue_if.sv
// Handshake bundle between the fetch buffer, the issue queue and the decoder.
// master = front end / decoder side, slave = the queue itself.
interface fetch_issue_queue_if;
    logic        flush;
    logic        pause;
    logic        in_valid;
    logic [1:0]  in_en;
    logic [31:0] in_inst0;
    logic [31:0] in_inst1;
    logic [31:0] in_pc0;
    logic [31:0] in_pc1;
    logic [1:0]  in_pre_taken;
    logic [31:0] in_pre_addr0;
    logic [31:0] in_pre_addr1;
    logic [1:0]  in_exc;
    logic [6:0]  in_exc_cause0;
    logic [6:0]  in_exc_cause1;
    logic        get_data_req;
    logic [1:0]  dec_accept;
    logic [1:0]  out_valid;
    logic [31:0] out_inst0;
    logic [31:0] out_inst1;
    logic [31:0] out_pc0;
    logic [31:0] out_pc1;
    logic [31:0] out_pre_addr0;
    logic [31:0] out_pre_addr1;
    logic [1:0]  out_pre_taken;
    logic [1:0]  out_exc;
    logic [6:0]  out_exc_cause0;
    logic [6:0]  out_exc_cause1;
    logic        empty;
    logic        full;

    modport master (
        output flush, pause, in_valid, in_en, in_inst0, in_inst1, in_pc0, in_pc1,
               in_pre_taken, in_pre_addr0, in_pre_addr1, in_exc, in_exc_cause0,
               in_exc_cause1, dec_accept,
        input  get_data_req, out_valid, out_inst0, out_inst1, out_pc0, out_pc1,
               out_pre_addr0, out_pre_addr1, out_pre_taken, out_exc, out_exc_cause0,
               out_exc_cause1, empty, full
    );

    modport slave (
        input  flush, pause, in_valid, in_en, in_inst0, in_inst1, in_pc0, in_pc1,
               in_pre_taken, in_pre_addr0, in_pre_addr1, in_exc, in_exc_cause0,
               in_exc_cause1, dec_accept,
        output get_data_req, out_valid, out_inst0, out_inst1, out_pc0, out_pc1,
               out_pre_addr0, out_pre_addr1, out_pre_taken, out_exc, out_exc_cause0,
               out_exc_cause1, empty, full
    );
endinterface

// File: rtl/fetch_issue_queue.sv
// Dual-slot circular FIFO decoupling fetch from decode: up to two pushes and two pops per cycle,
// oldest two entries always presented, flush drops everything.
module fetch_issue_queue #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned PTR_W = 3
) (
    input logic               cpu_clk,
    input logic               cpu_rst,
    fetch_issue_queue_if.slave bus
);

    typedef struct packed {
        logic [31:0] inst;
        logic [31:0] pc;
        logic [31:0] pre_addr;
        logic        pre_taken;
        logic        exc;
        logic [6:0]  exc_cause;
    } entry_t;

    localparam logic [PTR_W:0] PUSH_LIMIT = (PTR_W + 1)'(DEPTH - 2);
    localparam logic [PTR_W:0] FULL_CNT   = (PTR_W + 1)'(DEPTH);

    entry_t             mem_q [DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d, wr_ptr1;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d, rd_ptr1;
    logic [PTR_W:0]     count_q, count_d;
    logic [1:0]         n_wr, n_rd;
    logic [1:0]         valid;
    logic               push_ok;
    logic               wr_en;
    entry_t             wr_ent0, wr_ent1, rd_ent0, rd_ent1;

    // Two free slots are required so a full-width pair can never overflow.
    assign push_ok = cpu_rst & ~bus.flush & (count_q <= PUSH_LIMIT);
    assign bus.get_data_req = push_ok;

    assign wr_ptr1 = wr_ptr_q + PTR_W'(1);
    assign rd_ptr1 = rd_ptr_q + PTR_W'(1);

    assign wr_ent0 = '{inst: bus.in_inst0, pc: bus.in_pc0, pre_addr: bus.in_pre_addr0,
                       pre_taken: bus.in_pre_taken[0], exc: bus.in_exc[0],
                       exc_cause: bus.in_exc_cause0};
    assign wr_ent1 = '{inst: bus.in_inst1, pc: bus.in_pc1, pre_addr: bus.in_pre_addr1,
                       pre_taken: bus.in_pre_taken[1], exc: bus.in_exc[1],
                       exc_cause: bus.in_exc_cause1};

    always_comb begin
        n_wr = 2'd0;
        if (bus.in_valid && push_ok) begin
            case (bus.in_en)
                2'b01:   n_wr = 2'd1;
                2'b11:   n_wr = 2'd2;
                default: n_wr = 2'd0;
            endcase
        end
    end
    assign wr_en = (n_wr != 2'd0);

    assign valid = {count_q >= (PTR_W + 1)'(2), count_q != '0};

    // Mask 10 is not a legal decoder pattern and consumes nothing.
    always_comb begin
        n_rd = 2'd0;
        if (!bus.pause && !bus.flush) begin
            case (bus.dec_accept)
                2'b01:   n_rd = {1'b0, valid[0]};
                2'b11:   n_rd = {1'b0, valid[0]} + {1'b0, valid[1]};
                default: n_rd = 2'd0;
            endcase
        end
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q + PTR_W'(n_wr);
        rd_ptr_d = rd_ptr_q + PTR_W'(n_rd);
        count_d  = count_q + (PTR_W + 1)'(n_wr) - (PTR_W + 1)'(n_rd);
        if (bus.flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end
    end

    always_ff @(posedge cpu_clk or negedge cpu_rst) begin
        if (!cpu_rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Flush leaves storage intact; only reset clears it.
    always_ff @(posedge cpu_clk or negedge cpu_rst) begin
        if (!cpu_rst) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (wr_en) begin
            mem_q[wr_ptr_q] <= wr_ent0;
            if (n_wr == 2'd2) begin
                mem_q[wr_ptr1] <= wr_ent1;
            end
        end
    end

    assign rd_ent0 = mem_q[rd_ptr_q];
    assign rd_ent1 = mem_q[rd_ptr1];

    assign bus.out_valid      = valid;
    assign bus.out_inst0      = rd_ent0.inst;
    assign bus.out_inst1      = rd_ent1.inst;
    assign bus.out_pc0        = rd_ent0.pc;
    assign bus.out_pc1        = rd_ent1.pc;
    assign bus.out_pre_addr0  = rd_ent0.pre_addr;
    assign bus.out_pre_addr1  = rd_ent1.pre_addr;
    assign bus.out_pre_taken  = {rd_ent1.pre_taken, rd_ent0.pre_taken};
    assign bus.out_exc        = {rd_ent1.exc, rd_ent0.exc};
    assign bus.out_exc_cause0 = rd_ent0.exc_cause;
    assign bus.out_exc_cause1 = rd_ent1.exc_cause;
    assign bus.empty          = (count_q == '0);
    assign bus.full           = (count_q == FULL_CNT);

endmodule
